bram_load_ctrl: RTL and testbench



---
 rtl/bram_load_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_bram_load_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_load_ctrl.sv
// -----------------------------------------------------------------------------
// bram_load_ctrl
//
// Load sequencer for the 16-way feature/weight BRAM bank. A load command
// (first buffer, buffer count, words per buffer) is accepted in IDLE. Then a
// valid/ready stream of data words is written into the buffers. The word
// address is walked inside each buffer, and the buffer index is walked across
// buffers. This block is the only master of the shared address/data/write-enable
// bus that bram_mux fans out to the buffers using address bits [12:9].
//
// Optional feature (compile-time macro):
//   BRAM_LOAD_STAT_EN  - adds o_stall_cnt, a saturating count of LOAD cycles
//                        without valid input. It is cleared on each accepted
//                        start.
//
// Ports:
//   i_clk        in   clock, rising edge
//   i_rstn       in   asynchronous active-low reset
//   i_start      in   command strobe, sampled only in IDLE
//   i_buf_base   in   first buffer index
//   i_buf_cnt    in   buffers to fill (1..BUF_NUM)
//   i_word_cnt   in   words per buffer (1..2**WORD_AW)
//   i_valid      in   input word valid
//   i_data       in   input word
//   o_ready      out  input ready (state == LOAD)
//   o_bram_addr  out  registered write address {0, buf, 0, word}
//   o_bram_data  out  registered write data
//   o_bram_we    out  registered write enable
//   o_busy       out  state != IDLE
//   o_done       out  one-cycle completion pulse (state == DONE)
//   o_stall_cnt  out  [BRAM_LOAD_STAT_EN only] stall cycle counter
//   o_err        out  sticky illegal-command flag
// -----------------------------------------------------------------------------
module bram_load_ctrl #(
  parameter int ADDR_WIDTH   = 14,
  parameter int BRAM_DATA_WD = 32,
  parameter int BUF_NUM      = 16,
  parameter int WORD_AW      = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [3:0]              i_buf_base,
  input  logic [4:0]              i_buf_cnt,
  input  logic [WORD_AW:0]        i_word_cnt,
  input  logic                    i_valid,
  input  logic [BRAM_DATA_WD-1:0] i_data,
  output logic                    o_ready,
  output logic [ADDR_WIDTH-1:0]   o_bram_addr,
  output logic [BRAM_DATA_WD-1:0] o_bram_data,
  output logic                    o_bram_we,
  output logic                    o_busy,
  output logic                    o_done,
`ifdef BRAM_LOAD_STAT_EN
  output logic [15:0]             o_stall_cnt,
`endif
  output logic                    o_err
);

  localparam int BUF_AW = 4;

  // Sized limits so that the legality compares do not mix widths.
  localparam logic [BUF_AW:0]   BUF_CNT_MAX  = (BUF_AW + 1)'(BUF_NUM);
  localparam logic [BUF_AW+1:0] BUF_END_MAX  = (BUF_AW + 2)'(BUF_NUM);
  localparam logic [WORD_AW:0]  WORD_CNT_MAX = (WORD_AW + 1)'(1 << WORD_AW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [BUF_AW-1:0]    buf_q;        // absolute buffer index being written
  logic [WORD_AW-1:0]   word_q;       // word index inside the current buffer
  logic [BUF_AW-1:0]    last_buf_q;   // base + buf_cnt - 1
  logic [WORD_AW-1:0]   last_word_q;  // word_cnt - 1

  // ---------------------------------------------------------------------------
  // Command legality. The end index is one bit wider than a buffer index, so
  // base + cnt == 16 is still representable. Wrap past buffer 15 is rejected.
  // ---------------------------------------------------------------------------
  logic [BUF_AW+1:0] buf_end;
  logic              cmd_illegal;

  assign buf_end     = {2'b00, i_buf_base} + {1'b0, i_buf_cnt};
  assign cmd_illegal = (i_buf_cnt == '0)
                    || (i_buf_cnt > BUF_CNT_MAX)
                    || (i_word_cnt == '0)
                    || (i_word_cnt > WORD_CNT_MAX)
                    || (buf_end > BUF_END_MAX);

  // The last indices are derived in the narrow index width. A word count of
  // 2**WORD_AW truncates to 0, and 0 - 1 wraps to the top word. A buffer count
  // of 16 truncates to 0 in the same way, so base + 0 - 1 gives the top buffer.
  logic [WORD_AW-1:0] cmd_last_word;
  logic [BUF_AW-1:0]  cmd_last_buf;

  assign cmd_last_word = i_word_cnt[WORD_AW-1:0] - 1'b1;
  assign cmd_last_buf  = i_buf_base + i_buf_cnt[BUF_AW-1:0] - 1'b1;

  logic xfer;
  logic word_wrap;

  assign xfer      = (state_q == ST_LOAD) && i_valid;
  assign word_wrap = (word_q == last_word_q);

  // ---------------------------------------------------------------------------
  // Control FSM and registered write port
  // ---------------------------------------------------------------------------
  // NOTE: every register below is updated with non-blocking assignments, so
  // each right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      word_q      <= '0;
      last_buf_q  <= '0;
      last_word_q <= '0;
      o_bram_addr <= '0;
      o_bram_data <= '0;
      o_bram_we   <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      // Write enable is a single-cycle strobe per accepted word. Address and
      // data are only loaded on a transfer, so they hold while we is low.
      o_bram_we <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (cmd_illegal) begin
              o_err <= 1'b1;
            end else begin
              o_err       <= 1'b0;
              buf_q       <= i_buf_base;
              word_q      <= '0;
              last_buf_q  <= cmd_last_buf;
              last_word_q <= cmd_last_word;
              state_q     <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (xfer) begin
            o_bram_we   <= 1'b1;
            o_bram_addr <= {1'b0, buf_q, 1'b0, word_q};
            o_bram_data <= i_data;
            if (word_wrap) begin
              word_q <= '0;
              // After the last buffer this increment is never used, because
              // the FSM leaves LOAD on the same edge.
              buf_q  <= buf_q + 1'b1;
              if (buf_q == last_buf_q) begin
                state_q <= ST_DONE;
              end
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // These are decoded from the state register alone. o_done therefore lines
  // up with the final write strobe: both follow the last handshake edge.
  assign o_ready = (state_q == ST_LOAD);
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = (state_q == ST_DONE);

`ifdef BRAM_LOAD_STAT_EN
  // ---------------------------------------------------------------------------
  // Stall statistics: LOAD cycles with no input word, saturating.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stall_cnt <= '0;
    end else if ((state_q == ST_IDLE) && i_start && !cmd_illegal) begin
      o_stall_cnt <= '0;
    end else if ((state_q == ST_LOAD) && !i_valid && (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_load_ctrl.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for bram_load_ctrl.
// Inputs change 1 time unit after each rising edge. Outputs are checked at the
// same point, so they show the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_bram_load_ctrl;

  logic        i_clk;
  logic        i_rstn;
  logic        i_start;
  logic [3:0]  i_buf_base;
  logic [4:0]  i_buf_cnt;
  logic [8:0]  i_word_cnt;
  logic        i_valid;
  logic [31:0] i_data;
  logic        o_ready;
  logic [13:0] o_bram_addr;
  logic [31:0] o_bram_data;
  logic        o_bram_we;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
`ifdef BRAM_LOAD_STAT_EN
  logic [15:0] o_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bram_load_ctrl dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_start     (i_start),
    .i_buf_base  (i_buf_base),
    .i_buf_cnt   (i_buf_cnt),
    .i_word_cnt  (i_word_cnt),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_bram_addr (o_bram_addr),
    .o_bram_data (o_bram_data),
    .o_bram_we   (o_bram_we),
    .o_busy      (o_busy),
    .o_done      (o_done),
`ifdef BRAM_LOAD_STAT_EN
    .o_stall_cnt (o_stall_cnt),
`endif
    .o_err       (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: apply valid/data, take the edge, settle.
  task automatic cyc(input logic v, input logic [31:0] d);
    i_valid = v;
    i_data  = d;
    @(posedge i_clk);
    #1;
  endtask

  // Issue a command for one cycle with valid low.
  task automatic start_cmd(input logic [3:0] base, input logic [4:0] cnt, input logic [8:0] words);
    i_start    = 1'b1;
    i_buf_base = base;
    i_buf_cnt  = cnt;
    i_word_cnt = words;
    i_valid    = 1'b0;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [13:0] addr,
                        input logic [31:0] data, input logic done);
    check({tag, ".we"},   32'(o_bram_we),   32'(we));
    check({tag, ".addr"}, 32'(o_bram_addr), 32'(addr));
    check({tag, ".data"}, o_bram_data,      data);
    check({tag, ".done"}, 32'(o_done),      32'(done));
  endtask

  task automatic chk_idle_zero(input string tag);
    check({tag, ".ready"}, 32'(o_ready),     32'd0);
    check({tag, ".busy"},  32'(o_busy),      32'd0);
    check({tag, ".done"},  32'(o_done),      32'd0);
    check({tag, ".we"},    32'(o_bram_we),   32'd0);
    check({tag, ".err"},   32'(o_err),       32'd0);
    check({tag, ".addr"},  32'(o_bram_addr), 32'd0);
    check({tag, ".data"},  o_bram_data,      32'd0);
`ifdef BRAM_LOAD_STAT_EN
    check({tag, ".stall"}, 32'(o_stall_cnt), 32'd0);
`endif
  endtask

  initial begin
    logic [13:0] exp_addr;

    i_rstn     = 1'b0;
    i_start    = 1'b0;
    i_buf_base = '0;
    i_buf_cnt  = '0;
    i_word_cnt = '0;
    i_valid    = 1'b0;
    i_data     = '0;

    // ---------------- Reset state ----------------
    repeat (2) @(posedge i_clk);
    #1;
    chk_idle_zero("rst_hold");
    i_rstn = 1'b1;
    cyc(1'b1, 32'hDEAD_BEEF);           // valid in IDLE must not write
    chk_idle_zero("rst_rel");

    // ---------------- Single buffer: base 0, 1 buffer, 4 words ----------------
    start_cmd(4'd0, 5'd1, 9'd4);
    check("sb.ready", 32'(o_ready), 32'd1);
    check("sb.busy",  32'(o_busy),  32'd1);
    check("sb.we0",   32'(o_bram_we), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h1111_0000 + 32'(k));
      chk_wr($sformatf("sb.w%0d", k), 1'b1, 14'(k), 32'h1111_0000 + 32'(k), (k == 3));
      check($sformatf("sb.busy%0d", k), 32'(o_busy), 32'd1);
    end
    check("sb.ready_done", 32'(o_ready), 32'd0);
    cyc(1'b0, 32'h0);
    check("sb.busy_end", 32'(o_busy), 32'd0);
    chk_wr("sb.after", 1'b0, 14'h0003, 32'h1111_0003, 1'b0);

    // ---------------- Buffer crossing: base 14, 2 buffers, 256 words ----------
    start_cmd(4'd14, 5'd2, 9'd256);
    check("bx.ready", 32'(o_ready), 32'd1);
    for (int k = 0; k < 512; k++) begin
      exp_addr = (k < 256) ? (14'h1C00 + 14'(k)) : (14'h1E00 + 14'(k - 256));
      cyc(1'b1, 32'hC0DE_0000 ^ 32'(k));
      chk_wr($sformatf("bx.w%0d", k), 1'b1, exp_addr, 32'hC0DE_0000 ^ 32'(k), (k == 511));
    end
    cyc(1'b0, 32'h0);
    check("bx.busy_end", 32'(o_busy), 32'd0);
    check("bx.we_end",   32'(o_bram_we), 32'd0);

    // ---------------- Input bubbles: base 3, 1 buffer, 3 words ----------------
    // A start strobe with a different base is held during the load and
    // must be ignored.
    start_cmd(4'd3, 5'd1, 9'd3);
    cyc(1'b1, 32'hB0B0_0000);
    chk_wr("bb.w0", 1'b1, 14'h0600, 32'hB0B0_0000, 1'b0);
    i_start    = 1'b1;
    i_buf_base = 4'd0;
    cyc(1'b0, 32'hFFFF_FFFF);
    chk_wr("bb.gap1", 1'b0, 14'h0600, 32'hB0B0_0000, 1'b0);
    check("bb.ready1", 32'(o_ready), 32'd1);
    cyc(1'b0, 32'hFFFF_FFFF);
    chk_wr("bb.gap2", 1'b0, 14'h0600, 32'hB0B0_0000, 1'b0);
    cyc(1'b1, 32'hB0B0_0001);
    chk_wr("bb.w1", 1'b1, 14'h0601, 32'hB0B0_0001, 1'b0);
    i_start = 1'b0;
    cyc(1'b1, 32'hB0B0_0002);
    chk_wr("bb.w2", 1'b1, 14'h0602, 32'hB0B0_0002, 1'b1);
`ifdef BRAM_LOAD_STAT_EN
    check("bb.stall", 32'(o_stall_cnt), 32'd2);
`endif
    cyc(1'b0, 32'h0);
    check("bb.busy_end", 32'(o_busy), 32'd0);
`ifdef BRAM_LOAD_STAT_EN
    check("bb.stall_hold", 32'(o_stall_cnt), 32'd2);
`endif

    // ---------------- Illegal commands ----------------
    start_cmd(4'd15, 5'd2, 9'd4);       // wraps past buffer 15
    check("il.err",   32'(o_err),     32'd1);
    check("il.busy",  32'(o_busy),    32'd0);
    check("il.ready", 32'(o_ready),   32'd0);
    cyc(1'b1, 32'h0BAD_0000);
    check("il.we",    32'(o_bram_we), 32'd0);
    check("il.sticky", 32'(o_err),    32'd1);
    start_cmd(4'd0, 5'd0, 9'd4);        // zero buffers
    check("il.cnt0",  32'(o_busy),    32'd0);
    start_cmd(4'd0, 5'd17, 9'd4);       // too many buffers
    check("il.cnt17", 32'(o_busy),    32'd0);
    start_cmd(4'd0, 5'd1, 9'd0);        // zero words
    check("il.w0",    32'(o_busy),    32'd0);
    start_cmd(4'd0, 5'd1, 9'd257);      // too many words
    check("il.w257",  32'(o_busy),    32'd0);
    check("il.err2",  32'(o_err),     32'd1);

    // A legal start clears the error and writes word 0 of buffer 0.
    start_cmd(4'd0, 5'd1, 9'd1);
    check("lg.err_clr", 32'(o_err),   32'd0);
    check("lg.ready",   32'(o_ready), 32'd1);
    cyc(1'b1, 32'h600D_0001);
    chk_wr("lg.w0", 1'b1, 14'h0000, 32'h600D_0001, 1'b1);
    cyc(1'b0, 32'h0);
    check("lg.busy_end", 32'(o_busy), 32'd0);

    // Boundary: all 16 buffers, one word each. Buffer k lands at k << 9.
    start_cmd(4'd0, 5'd16, 9'd1);
    check("f16.err", 32'(o_err), 32'd0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 32'hF16F_0000 + 32'(k));
      chk_wr($sformatf("f16.w%0d", k), 1'b1, 14'(k * 512), 32'hF16F_0000 + 32'(k), (k == 15));
    end
    cyc(1'b0, 32'h0);

    // ---------------- Reset mid-load ----------------
    start_cmd(4'd0, 5'd1, 9'd256);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 32'hAAAA_0000 + 32'(k));
      check($sformatf("rm.addr%0d", k), 32'(o_bram_addr), 32'(k));
    end
    i_valid = 1'b0;
    i_rstn  = 1'b0;                     // asynchronous: no edge needed
    #1;
    chk_idle_zero("rm.async");
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    cyc(1'b0, 32'h0);
    chk_idle_zero("rm.idle");

    start_cmd(4'd5, 5'd1, 9'd2);
    check("rm.ready", 32'(o_ready), 32'd1);
    cyc(1'b1, 32'h5A5A_0000);
    chk_wr("rm.w0", 1'b1, 14'h0A00, 32'h5A5A_0000, 1'b0);
    cyc(1'b1, 32'h5A5A_0001);
    chk_wr("rm.w1", 1'b1, 14'h0A01, 32'h5A5A_0001, 1'b1);
`ifdef BRAM_LOAD_STAT_EN
    check("rm.stall", 32'(o_stall_cnt), 32'd0);
`endif
    cyc(1'b0, 32'h0);
    check("rm.busy_end", 32'(o_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
